uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  Serialises one byte per handshake onto the UART TX line: 8N1 frame, LSB first.
//  It is the device-side consumer of the CPU memory-mapped UART port.
//  - DataIn and DataInValid come from the store path at address 0x80000008.
//  - DataInReady is polled by the CPU at address 0x80000000.
//  - SOut drives the board serial pin.
// PARAMETERS
//  CLOCK_FREQ  33_000_000  system clock frequency, Hz
//  BAUD_RATE   115_200     line rate, bits/s
//  (derived)   SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, integer division; must be >= 2
//  (derived)   CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
// PORTS
//  Clock        in   1  system clock; all state changes on the rising edge
//  Reset_n      in   1  synchronous, active-low reset
//  DataIn       in   8  byte to transmit; sampled only on an accepting edge
//  DataInValid  in   1  producer has a byte; single-cycle pulses allowed
//  DataInReady  out  1  block can accept a byte this cycle
//  SOut         out  1  serial line; idle level is 1
// BEHAVIOUR
//  - Reset (Reset_n=0 at an edge):
//    - registers after the edge: SOut=1, state=IDLE, counters=0, buffer empty.
//    - DataInReady=1 in the same cycle.
//  - Handshake: a byte is accepted at a rising edge where DataInValid && DataInReady.
//    - DataInValid with DataInReady=0: the byte is dropped, no state change.
//    - The producer must not rely on backpressure; software polls DataInReady first.
//  - DataInReady is combinational from state.
//    - Buffer disabled: DataInReady = (state==IDLE).
//    - Buffer enabled: DataInReady = !buf_full.
//  - FSM states: IDLE, START, DATA, STOP.
//    - IDLE  -> START on accept: shift reg <= DataIn, clk_cnt <= 0, bit_cnt <= 0.
//    - START: SOut=0 for SYMBOL_EDGE_TIME cycles, then -> DATA.
//    - DATA: SOut=shift[0] for SYMBOL_EDGE_TIME cycles per bit.
//      - At each bit end: shift right, bit_cnt++.
//      - After bit_cnt reaches 7 and its bit ends: -> STOP.
//    - STOP: SOut=1 for SYMBOL_EDGE_TIME cycles, then -> IDLE, or START if the buffer is full.
//  - SOut is registered.
//  - Timing (accept at edge t0, S = SYMBOL_EDGE_TIME):
//    - start bit occupies cycles t0+1 .. t0+S.
//    - data bit i occupies cycles t0+1+(i+1)*S .. t0+(i+2)*S.
//    - stop bit occupies cycles t0+1+9*S .. t0+10*S.
//    - each bit is held exactly S cycles, no jitter.
//  - clk_cnt counts 0..S-1 and wraps to 0 at the bit boundary; no other wrap.
//    - bit_cnt is 3 bits and never wraps mid-frame.
//  - Back-to-back without buffer:
//    - IDLE is re-entered at edge t0+10*S, so DataInReady=1 in cycle t0+10*S+1.
//    - earliest next start bit is cycle t0+10*S+2, i.e. at least one idle-high cycle between frames.
//  - Accept and frame-end on the same edge (buffer enabled): both take effect.
//    - the shifter loads the held byte; the new byte fills the buffer.
//  - Reset mid-frame: frame aborted.
//    - SOut=1 from the next cycle; buffered byte discarded; no partial frame resumes.
//  - SOut must never glitch low while in IDLE.
// CONFIGURATION
//  UART_TX_BUF_EN defined: one-byte holding register ahead of the shifter.
//    - bytes may be accepted while shifting (buffer empty).
//    - at the STOP end with buffer full: -> START directly; next start bit begins in cycle t0+10*S+1.
//    - frames are back-to-back with no idle gap; each frame is exactly 10*S cycles.
//  UART_TX_BUF_EN undefined: no holding register.
//    - DataInReady=0 from the accept edge until IDLE is re-entered, as above.
// TESTING (CLOCK_FREQ=1000, BAUD_RATE=100 -> S=10)
//  - Reset_n=0 for 3 cycles then 1
//    -> SOut=1 and DataInReady=1 every cycle; no transitions for 200 cycles.
//  - Accept 0xA5 at edge t0
//    -> SOut per 10-cycle slot from t0+1: 0,1,0,1,0,0,1,0,1,1.
//    -> DataInReady=0 over t0+1..t0+10*S, then 1.
//  - DataInValid pulse with 0x3C at t0+25 during a 0xA5 frame (no buffer)
//    -> ignored; SOut pattern identical to the 0xA5 case; only one frame emitted.
//  - Reset_n=0 at t0+45 mid-frame
//    -> SOut=1 from t0+46; DataInReady=1; accept 0x00 later -> clean full frame.
//  - UART_TX_BUF_EN: accept 0x55 at t0, then 0x0F at t0+3
//    -> DataInReady=0 after t0+3.
//    -> second start bit at t0+101; 20*S contiguous cycles of valid frames; DataInReady=1 at t0+101.
//  - Loopback: feed SOut to the existing UART receiver, send 0x00, 0xFF, 0x80, 0x01
//    -> receiver DataOut matches each, DataOutValid pulses once per byte.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the CPU store path and the UART transmitter.
// Producer drives DataIn/DataInValid; transmitter answers with DataInReady.
interface uart_transmitter_if;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;

  modport master (
    output DataIn,
    output DataInValid,
    input  DataInReady
  );

  modport slave (
    input  DataIn,
    input  DataInValid,
    output DataInReady
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, registered serial output.
// Optional UART_TX_BUF_EN adds a one-byte holding register ahead of the shifter.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic          Clock,
  input  logic          Reset_n,
  uart_transmitter_if.slave in_if,
  output logic          SOut
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam int CW                  = CLOCK_COUNTER_WIDTH;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            sout_q, sout_d;

  logic            ready;
  logic            accept;
  logic            bit_end;
  logic            load;
  logic [7:0]      next_byte;

`ifdef UART_TX_BUF_EN
  logic [7:0]      buf_q, buf_d;
  logic            buf_full_q, buf_full_d;

  // Holding register: a queued byte always wins the shifter slot
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    ready      = !buf_full_q;
    accept     = in_if.DataInValid && ready;
    next_byte  = buf_full_q ? buf_q : in_if.DataIn;
    load       = (buf_full_q || accept) &&
                 ((state_q == IDLE) ||
                  ((state_q == STOP) && bit_end));
    if (load && buf_full_q) begin
      buf_full_d = 1'b0;
    end
    if (accept && !(load && !buf_full_q)) begin
      buf_d      = in_if.DataIn;
      buf_full_d = 1'b1;
    end
  end

  // Holding register state
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`else
  // Without a buffer the shifter only takes bytes while idle
  always_comb begin
    ready     = (state_q == IDLE);
    accept    = in_if.DataInValid && ready;
    next_byte = in_if.DataIn;
    load      = accept;
  end
`endif

  assign bit_end           = (clk_cnt_q == CNT_MAX);
  assign in_if.DataInReady = ready;
  assign SOut              = sout_q;

  // Frame sequencer: next state, counters, shifter and line level
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sout_d    = sout_q;

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        sout_d = 1'b1;
        if (load) begin
          state_d   = START;
          shift_d   = next_byte;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          sout_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          sout_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = '0;
            sout_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sout_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (load) begin
            state_d   = START;
            shift_d   = next_byte;
            bit_cnt_d = '0;
            sout_d    = 1'b0;
          end else begin
            state_d = IDLE;
            sout_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = 1'b1;
      end
    endcase
  end

  // Sequencer state; reset aborts any frame and idles the line high
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sout_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sout_q    <= sout_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at S = 1000/100 = 10 cycles per bit.
// Frame slots are hand-written as {stop, data[7:0], start}.
module tb_uart_transmitter;

  localparam int S = 10;

`ifdef UART_TX_BUF_EN
  localparam logic BUSY_READY = 1'b1;
  localparam int   DROP_AT    = -1;
`else
  localparam logic BUSY_READY = 1'b0;
  localparam int   DROP_AT    = 25;
`endif

  typedef struct {
    logic [7:0] d;
    logic [9:0] slots;
    int         drop_at;
    int         rst_at;
  } vec_t;

  logic clk;
  logic rst_n;
  logic sout;

  int n_tests;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rx_busy;
  int         rx_cnt;
  logic [7:0] rx_sh;

  uart_transmitter_if tx_if();

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .Clock  (clk),
    .Reset_n(rst_n),
    .in_if  (tx_if),
    .SOut   (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent line sampler: mid-bit sampling, one entry per good frame
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (sout === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == S / 2) begin
        if (sout !== 1'b0) rx_busy <= 1'b0;
      end else if (rx_cnt > S && ((rx_cnt - S / 2) % S) == 0) begin
        if ((rx_cnt - S / 2) / S <= 8) begin
          rx_sh <= {sout, rx_sh[7:1]};
        end else begin
          if (sout === 1'b1) rx_q.push_back(rx_sh);
          rx_busy <= 1'b0;
        end
      end
    end
  end

  // Sends one byte and checks every cycle of its frame
  task automatic run_frame(input vec_t v);
    logic aborted;
    aborted = 1'b0;
    check("pre_ready", tx_if.DataInReady, 1'b1);
    tx_if.DataIn      = v.d;
    tx_if.DataInValid = 1'b1;
    tick();
    tx_if.DataInValid = 1'b0;
    tx_if.DataIn      = 8'h00;
    for (int c = 1; c <= 10 * S; c++) begin
      check("frame_sout", sout, v.slots[(c - 1) / S]);
      check("frame_ready", tx_if.DataInReady, BUSY_READY);
      if (c == v.drop_at) begin
        tx_if.DataIn      = 8'h3C;
        tx_if.DataInValid = 1'b1;
      end else begin
        tx_if.DataInValid = 1'b0;
      end
      if (c == v.rst_at) rst_n = 1'b0;
      tick();
      if (c == v.rst_at) begin
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          check("abort_sout", sout, 1'b1);
          check("abort_ready", tx_if.DataInReady, 1'b1);
          tick();
        end
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check("post_sout", sout, 1'b1);
      check("post_ready", tx_if.DataInReady, 1'b1);
      if (v.rst_at < 0) exp_q.push_back(v.d);
      if (v.drop_at > 0) begin
        for (int k = 0; k < 30; k++) begin
          check("single_frame", sout, 1'b1);
          tick();
        end
      end
    end
  endtask

  task automatic check_rx();
    check("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check("rx_byte", rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rx_busy = 1'b0;
    rx_cnt  = 0;
    rx_sh   = 8'h00;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, -1, -1};
    vecs[1] = '{8'hA5, 10'b1_10100101_0, DROP_AT, -1};
    vecs[2] = '{8'hA5, 10'b1_10100101_0, -1, 45};
    vecs[3] = '{8'h00, 10'b1_00000000_0, -1, -1};
    vecs[4] = '{8'hFF, 10'b1_11111111_0, -1, -1};
    vecs[5] = '{8'h80, 10'b1_10000000_0, -1, -1};
    vecs[6] = '{8'h01, 10'b1_00000001_0, -1, -1};

    rst_n             = 1'b0;
    tx_if.DataIn      = 8'h00;
    tx_if.DataInValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_sout", sout, 1'b1);
      check("rst_ready", tx_if.DataInReady, 1'b1);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      check("idle_sout", sout, 1'b1);
      check("idle_ready", tx_if.DataInReady, 1'b1);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
    end
    for (int k = 0; k < 5; k++) tick();
    check_rx();

`ifdef UART_TX_BUF_EN
    tx_if.DataIn      = 8'h55;
    tx_if.DataInValid = 1'b1;
    tick();
    tx_if.DataInValid = 1'b0;
    for (int c = 1; c <= 20 * S; c++) begin
      logic [9:0] slots;
      slots = (c <= 10 * S) ? 10'b1_01010101_0 : 10'b1_00001111_0;
      check("buf_sout", sout, slots[((c - 1) / S) % 10]);
      check("buf_ready", tx_if.DataInReady,
            (c <= 3 || c >= 101) ? 1'b1 : 1'b0);
      if (c == 3) begin
        tx_if.DataIn      = 8'h0F;
        tx_if.DataInValid = 1'b1;
      end else begin
        tx_if.DataInValid = 1'b0;
      end
      tick();
    end
    check("buf_post_sout", sout, 1'b1);
    check("buf_post_ready", tx_if.DataInReady, 1'b1);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    for (int k = 0; k < 5; k++) tick();
    check_rx();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
